// File: rtl/ex_unit.sv
// ex_unit: RV32I execute stage (ALU, branch resolve, bit-serial shifter, EX/MEM register).
// Define EX_MULDIV_EN to add the iterative M-extension (muldiv_in port, MULDIV state).
module ex_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_in,
  input  logic [10:0]     opcode_in,
  input  logic [XLEN-1:0] data1_in,
  input  logic [XLEN-1:0] data2_in,
  input  logic [4:0]      Rd_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] imm_in,
`ifdef EX_MULDIV_EN
  input  logic            muldiv_in,
`endif
  output logic [10:0]     opcode_out,
  output logic [XLEN-1:0] result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      Rd_out,
  output logic            busy_out,
  output logic            jump_flag_out,
  output logic [XLEN-1:0] jump_target_out
);
  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_OPIMM = 7'h13,
    OPC_OP = 7'h33, OPC_LOAD = 7'h03, OPC_STORE = 7'h23, OPC_JAL = 7'h6f,
    OPC_JALR = 7'h67, OPC_BRANCH = 7'h63;

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, MULDIV} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  state_t state;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            b10, is_op, is_alu, is_shift, md_op, shift_start, busy_int;
  logic            cond, taken, valid;
  logic [4:0]      shamt, rd_d, rd_q, n_rd;
  logic [5:0]      cnt;
  logic [10:0]     op_q, n_op;
  logic [XLEN-1:0] opb, alu, res, addr, tgt, acc, sh_nxt, done_res, n_res, n_sd;

  assign opc      = opcode_in[6:0];
  assign f3       = opcode_in[9:7];
  assign b10      = opcode_in[10];
  assign is_op    = (opc == OPC_OP);
  assign is_alu   = is_op || (opc == OPC_OPIMM);
  assign opb      = is_op ? data2_in : imm_in;
  assign shamt    = opb[4:0];
  assign addr     = data1_in + imm_in;
`ifdef EX_MULDIV_EN
  assign md_op    = is_op & muldiv_in;
`else
  assign md_op    = 1'b0;
`endif
  assign is_shift    = is_alu && (f3 == 3'b001 || f3 == 3'b101) && !md_op;
  assign shift_start = is_shift && (shamt != 5'd0);

  // Zero-amount shifts fall through the ALU as a plain copy of data1.
  always_comb begin
    alu = '0;
    case (f3)
      3'b000: alu = (is_op && b10) ? data1_in - opb : data1_in + opb;
      3'b010: alu = {{(XLEN-1){1'b0}}, $signed(data1_in) < $signed(opb)};
      3'b011: alu = {{(XLEN-1){1'b0}}, data1_in < opb};
      3'b100: alu = data1_in ^ opb;
      3'b110: alu = data1_in | opb;
      3'b111: alu = data1_in & opb;
      default: alu = data1_in;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (f3)
      3'b000: cond = (data1_in == data2_in);
      3'b001: cond = (data1_in != data2_in);
      3'b100: cond = $signed(data1_in) < $signed(data2_in);
      3'b101: cond = $signed(data1_in) >= $signed(data2_in);
      3'b110: cond = data1_in < data2_in;
      3'b111: cond = data1_in >= data2_in;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    valid = 1'b1;
    res   = '0;
    rd_d  = Rd_in;
    case (opc)
      OPC_LUI:              res = imm_in;
      OPC_AUIPC:            res = pc_in + imm_in;
      OPC_OPIMM, OPC_OP:    res = alu;
      OPC_LOAD, OPC_STORE:  res = addr;
      OPC_JAL, OPC_JALR:    res = pc_in + 32'd4;
      OPC_BRANCH:           rd_d = '0;
      default: begin valid = 1'b0; rd_d = '0; end
    endcase
  end

  assign taken = (opc == OPC_JAL) || (opc == OPC_JALR) || (opc == OPC_BRANCH && cond);
  assign tgt   = (opc == OPC_JALR) ? {addr[XLEN-1:1], 1'b0} : pc_in + imm_in;

  assign busy_int        = (state == IDLE) ? (shift_start | md_op) : (state != DONE);
  assign busy_out        = !rst && (stall_in || busy_int);
  assign jump_flag_out   = !rst && !stall_in && (state == IDLE) && taken;
  assign jump_target_out = jump_flag_out ? tgt : '0;

  assign sh_nxt = (op_q[9:7] == 3'b001) ? {acc[XLEN-2:0], 1'b0}
                                        : {op_q[10] & acc[XLEN-1], acc[XLEN-1:1]};

`ifdef EX_MULDIV_EN
  // Signed ops run on magnitudes; signs are re-applied when the result is taken in DONE.
  logic        md_q, md_qneg, md_rneg, md_dz, md_sa, md_sb, md_an, md_bn;
  logic [63:0] md_acc, md_nxt, md_prod;
  logic [31:0] md_opnd, md_dvd, md_amag, md_bmag, md_diff, md_quo, md_rem, md_res;
  logic [32:0] md_sum, md_up;

  assign md_sa   = f3[2] ? !f3[0] : (f3[1:0] == 2'b01 || f3[1:0] == 2'b10);
  assign md_sb   = f3[2] ? !f3[0] : (f3[1:0] == 2'b01);
  assign md_an   = md_sa & data1_in[31];
  assign md_bn   = md_sb & data2_in[31];
  assign md_amag = md_an ? -data1_in : data1_in;
  assign md_bmag = md_bn ? -data2_in : data2_in;
  assign md_sum  = {1'b0, md_acc[63:32]} + (md_acc[0] ? {1'b0, md_opnd} : 33'd0);
  assign md_up   = md_acc[63:31];
  assign md_diff = md_up[31:0] - md_opnd;
  assign md_nxt  = !op_q[9] ? {md_sum, md_acc[31:1]}
                 : (md_up >= {1'b0, md_opnd}) ? {md_diff, md_acc[30:0], 1'b1}
                 : {md_acc[62:0], 1'b0};
  assign md_prod = md_qneg ? -md_acc : md_acc;
  assign md_quo  = md_qneg ? -md_acc[31:0] : md_acc[31:0];
  assign md_rem  = md_rneg ? -md_acc[63:32] : md_acc[63:32];
  assign md_res  = !op_q[9] ? ((op_q[8:7] == 2'b00) ? md_prod[31:0] : md_prod[63:32])
                 : md_dz    ? (op_q[8] ? md_dvd : 32'hffff_ffff)
                 : (op_q[8] ? md_rem : md_quo);
  assign done_res = md_q ? md_res : acc;
`else
  assign done_res = acc;
`endif

  // Next EX/MEM contents; anything other than a finished or single-cycle op is a bubble.
  always_comb begin
    n_op = '0; n_res = '0; n_rd = '0; n_sd = '0;
    if (state == DONE) begin
      n_op = op_q; n_res = done_res; n_rd = rd_q;
    end else if (state == IDLE && !busy_int && valid) begin
      n_op = opcode_in; n_res = res; n_rd = rd_d; n_sd = data2_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; cnt <= '0; acc <= '0; op_q <= '0; rd_q <= '0;
      opcode_out <= '0; result_out <= '0; store_data_out <= '0; Rd_out <= '0;
`ifdef EX_MULDIV_EN
      md_q <= 1'b0; md_qneg <= 1'b0; md_rneg <= 1'b0; md_dz <= 1'b0;
      md_acc <= '0; md_opnd <= '0; md_dvd <= '0;
`endif
    end else if (!stall_in) begin
      opcode_out <= n_op; result_out <= n_res; Rd_out <= n_rd; store_data_out <= n_sd;
      case (state)
        IDLE: begin
          op_q <= opcode_in;
          rd_q <= Rd_in;
          if (shift_start) begin
            acc <= data1_in; cnt <= {1'b0, shamt}; state <= SHIFT;
`ifdef EX_MULDIV_EN
            md_q <= 1'b0;
          end else if (md_op) begin
            md_q <= 1'b1; md_qneg <= md_an ^ md_bn; md_rneg <= md_an;
            md_dz <= (data2_in == '0); md_dvd <= data1_in;
            md_acc <= {32'd0, f3[2] ? md_amag : md_bmag};
            md_opnd <= f3[2] ? md_bmag : md_amag;
            cnt <= 6'd32; state <= MULDIV;
`endif
          end
        end
        SHIFT: begin
          acc <= sh_nxt; cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= DONE;
        end
`ifdef EX_MULDIV_EN
        MULDIV: begin
          md_acc <= md_nxt; cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_unit.sv
// tb_ex_unit: directed vectors, multi-cycle corner sequences and randomized
// instructions for ex_unit, checked against a behavioural reference model.
module tb_ex_unit;
  logic        clk = 1'b0, rst = 1'b1, stall_in = 1'b0;
  logic [10:0] opcode_in = '0;
  logic [31:0] data1_in = '0, data2_in = '0, pc_in = '0, imm_in = '0;
  logic [4:0]  Rd_in = '0;
`ifdef EX_MULDIV_EN
  logic        muldiv_in = 1'b0;
`endif
  logic [10:0] opcode_out;
  logic [31:0] result_out, store_data_out, jump_target_out;
  logic [4:0]  Rd_out;
  logic        busy_out, jump_flag_out;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  ex_unit dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .opcode_in(opcode_in),
    .data1_in(data1_in), .data2_in(data2_in), .Rd_in(Rd_in), .pc_in(pc_in), .imm_in(imm_in),
`ifdef EX_MULDIV_EN
    .muldiv_in(muldiv_in),
`endif
    .opcode_out(opcode_out), .result_out(result_out), .store_data_out(store_data_out),
    .Rd_out(Rd_out), .busy_out(busy_out), .jump_flag_out(jump_flag_out),
    .jump_target_out(jump_target_out)
  );

  typedef struct {
    logic [10:0] op;
    logic [31:0] d1, d2;
    logic [4:0]  rd;
    logic [31:0] pc, imm;
    logic        md;
    logic        e_vld;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    logic        e_jmp;
    logic [31:0] e_tgt;
    int          e_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [10:0] mk(input logic b, input logic [2:0] f, input logic [6:0] o);
    return {b, f, o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: architectural result of one instruction plus its busy-cycle count.
  function automatic void model(inout vec_t v);
    logic [6:0]  o;
    logic [2:0]  f;
    logic [31:0] b;
    int          sh, sa, sb;
    longint      p;
    o = v.op[6:0]; f = v.op[9:7];
    v.e_vld = 1'b1; v.e_res = '0; v.e_rd = v.rd; v.e_jmp = 1'b0; v.e_tgt = '0; v.e_busy = 0;
    case (o)
      7'h37: v.e_res = v.imm;
      7'h17: v.e_res = v.pc + v.imm;
      7'h03, 7'h23: v.e_res = v.d1 + v.imm;
      7'h6f: begin v.e_res = v.pc + 4; v.e_jmp = 1'b1; v.e_tgt = v.pc + v.imm; end
      7'h67: begin v.e_res = v.pc + 4; v.e_jmp = 1'b1; v.e_tgt = (v.d1 + v.imm) & 32'hffff_fffe; end
      7'h63: begin
        v.e_rd = '0;
        case (f)
          3'd0: v.e_jmp = (v.d1 == v.d2);
          3'd1: v.e_jmp = (v.d1 != v.d2);
          3'd4: v.e_jmp = ($signed(v.d1) < $signed(v.d2));
          3'd5: v.e_jmp = ($signed(v.d1) >= $signed(v.d2));
          3'd6: v.e_jmp = (v.d1 < v.d2);
          3'd7: v.e_jmp = (v.d1 >= v.d2);
          default: v.e_jmp = 1'b0;
        endcase
        if (v.e_jmp) v.e_tgt = v.pc + v.imm;
      end
      7'h13, 7'h33: begin
        b = (o == 7'h33) ? v.d2 : v.imm;
        sh = int'(b[4:0]);
        sa = v.d1; sb = v.d2;
        if (o == 7'h33 && v.md) begin
          v.e_busy = 33;
          case (f)
            3'd0: v.e_res = v.d1 * v.d2;
            3'd1: begin p = longint'(sa) * longint'(sb); v.e_res = p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'd0, v.d2}); v.e_res = p[63:32]; end
            3'd3: begin p = longint'({32'd0, v.d1}) * longint'({32'd0, v.d2}); v.e_res = p[63:32]; end
            3'd4: v.e_res = (v.d2 == 0) ? 32'hffff_ffff :
                            (v.d1 == 32'h8000_0000 && v.d2 == 32'hffff_ffff) ? 32'h8000_0000 : sa / sb;
            3'd5: v.e_res = (v.d2 == 0) ? 32'hffff_ffff : v.d1 / v.d2;
            3'd6: v.e_res = (v.d2 == 0) ? v.d1 :
                            (v.d1 == 32'h8000_0000 && v.d2 == 32'hffff_ffff) ? 32'd0 : sa % sb;
            default: v.e_res = (v.d2 == 0) ? v.d1 : v.d1 % v.d2;
          endcase
        end else begin
          case (f)
            3'd0: v.e_res = (o == 7'h33 && v.op[10]) ? v.d1 - b : v.d1 + b;
            3'd1: v.e_res = v.d1 << sh;
            3'd2: v.e_res = ($signed(v.d1) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: v.e_res = (v.d1 < b) ? 32'd1 : 32'd0;
            3'd4: v.e_res = v.d1 ^ b;
            3'd5: if (v.op[10]) v.e_res = $signed(v.d1) >>> sh;
                  else v.e_res = v.d1 >> sh;
            3'd6: v.e_res = v.d1 | b;
            default: v.e_res = v.d1 & b;
          endcase
          if ((f == 3'd1 || f == 3'd5) && sh != 0) v.e_busy = sh + 1;
        end
      end
      default: begin v.e_vld = 1'b0; v.e_rd = '0; end
    endcase
  endfunction

  // Apply one instruction at posedge+1 and follow it until it leaves EX/MEM.
  task automatic exec(input vec_t v, input string nm);
    int   nb;
    logic bub;
    opcode_in = v.op; data1_in = v.d1; data2_in = v.d2; Rd_in = v.rd;
    pc_in = v.pc; imm_in = v.imm;
`ifdef EX_MULDIV_EN
    muldiv_in = v.md;
`endif
    nb = 0; bub = 1'b1;
    @(negedge clk);
    chk({nm, ".jmp"}, 32'(jump_flag_out), 32'(v.e_jmp));
    chk({nm, ".tgt"}, jump_target_out, v.e_tgt);
    while (busy_out && nb < 60) begin
      nb++;
      @(posedge clk); #1;
      if (opcode_out !== '0 || Rd_out !== '0) bub = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk({nm, ".busy"}, 32'(nb), 32'(v.e_busy));
    if (v.e_busy > 0) chk({nm, ".bubble"}, 32'(bub), 32'd1);
    chk({nm, ".op"}, 32'(opcode_out), v.e_vld ? 32'(v.op) : 32'd0);
    chk({nm, ".res"}, result_out, v.e_res);
    chk({nm, ".rd"}, 32'(Rd_out), 32'(v.e_rd));
    if (v.op[6:0] == 7'h23) chk({nm, ".sd"}, store_data_out, v.d2);
  endtask

  function automatic logic [6:0] pick(input int k);
    case (k)
      0: return 7'h37;  1: return 7'h17;  2: return 7'h13;  3: return 7'h33;
      4: return 7'h03;  5: return 7'h23;  6: return 7'h6f;  7: return 7'h67;
      8: return 7'h63;  9: return 7'h00;  default: return 7'h7f;
    endcase
  endfunction

  initial begin
    vec_t r;
    // op, d1, d2, rd, pc, imm, md, e_vld, e_res, e_rd, e_jmp, e_tgt, e_busy
    tbl.push_back('{mk(0,0,7'h33), 32'd5, 32'd7, 5'd3, 32'h0, 32'h0, 1'b0, 1'b1, 32'd12, 5'd3, 1'b0, 32'h0, 0});
    tbl.push_back('{mk(0,1,7'h13), 32'd1, 32'd0, 5'd5, 32'h0, 32'd3, 1'b0, 1'b1, 32'd8, 5'd5, 1'b0, 32'h0, 4});
    tbl.push_back('{mk(1,5,7'h13), 32'h8000_0000, 32'd0, 5'd6, 32'h0, 32'h404, 1'b0, 1'b1, 32'hf800_0000, 5'd6, 1'b0, 32'h0, 5});
    tbl.push_back('{mk(0,0,7'h63), 32'd9, 32'd9, 5'd7, 32'h100, 32'h20, 1'b0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h120, 0});
    tbl.push_back('{mk(0,0,7'h63), 32'd9, 32'd8, 5'd7, 32'h100, 32'h20, 1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 0});
    tbl.push_back('{mk(0,0,7'h67), 32'h1003, 32'd0, 5'd1, 32'h40, 32'd4, 1'b0, 1'b1, 32'h44, 5'd1, 1'b1, 32'h1006, 0});
    tbl.push_back('{mk(1,0,7'h33), 32'd3, 32'd5, 5'd2, 32'h0, 32'h0, 1'b0, 1'b1, 32'hffff_fffe, 5'd2, 1'b0, 32'h0, 0});
    tbl.push_back('{mk(0,2,7'h33), 32'hffff_ffff, 32'd1, 5'd8, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1, 5'd8, 1'b0, 32'h0, 0});
    tbl.push_back('{mk(0,3,7'h33), 32'hffff_ffff, 32'd1, 5'd8, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0, 5'd8, 1'b0, 32'h0, 0});
    tbl.push_back('{mk(0,0,7'h37), 32'h0, 32'h0, 5'd9, 32'h0, 32'h1234_5000, 1'b0, 1'b1, 32'h1234_5000, 5'd9, 1'b0, 32'h0, 0});
    tbl.push_back('{mk(0,0,7'h17), 32'h0, 32'h0, 5'd10, 32'h1000, 32'hffff_f000, 1'b0, 1'b1, 32'h0, 5'd10, 1'b0, 32'h0, 0});
    tbl.push_back('{mk(0,2,7'h23), 32'h100, 32'hdead_beef, 5'd0, 32'h0, 32'hffff_fffc, 1'b0, 1'b1, 32'hfc, 5'd0, 1'b0, 32'h0, 0});
    tbl.push_back('{11'd0, 32'd1, 32'd2, 5'd9, 32'h0, 32'd3, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 0});
    tbl.push_back('{mk(0,0,7'h7f), 32'd1, 32'd2, 5'd9, 32'h0, 32'd3, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 0});
    tbl.push_back('{mk(0,1,7'h13), 32'habcd, 32'd0, 5'd4, 32'h0, 32'h0, 1'b0, 1'b1, 32'habcd, 5'd4, 1'b0, 32'h0, 0});
    tbl.push_back('{mk(0,5,7'h33), 32'hf0, 32'h24, 5'd4, 32'h0, 32'h0, 1'b0, 1'b1, 32'hf, 5'd4, 1'b0, 32'h0, 5});
    tbl.push_back('{mk(0,0,7'h6f), 32'h0, 32'h0, 5'd1, 32'h200, 32'hffff_fff0, 1'b0, 1'b1, 32'h204, 5'd1, 1'b1, 32'h1f0, 0});
    tbl.push_back('{mk(0,6,7'h63), 32'd1, 32'hffff_ffff, 5'd3, 32'h0, 32'd8, 1'b0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h8, 0});
    tbl.push_back('{mk(0,5,7'h63), 32'hffff_ffff, 32'd1, 5'd3, 32'h0, 32'd8, 1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 32'h0, 0});
`ifdef EX_MULDIV_EN
    tbl.push_back('{mk(0,4,7'h33), 32'd7, 32'd0, 5'd11, 32'h0, 32'h0, 1'b1, 1'b1, 32'hffff_ffff, 5'd11, 1'b0, 32'h0, 33});
    tbl.push_back('{mk(0,6,7'h33), 32'd7, 32'd0, 5'd11, 32'h0, 32'h0, 1'b1, 1'b1, 32'd7, 5'd11, 1'b0, 32'h0, 33});
    tbl.push_back('{mk(0,4,7'h33), 32'h8000_0000, 32'hffff_ffff, 5'd12, 32'h0, 32'h0, 1'b1, 1'b1, 32'h8000_0000, 5'd12, 1'b0, 32'h0, 33});
    tbl.push_back('{mk(0,6,7'h33), 32'h8000_0000, 32'hffff_ffff, 5'd12, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 5'd12, 1'b0, 32'h0, 33});
    tbl.push_back('{mk(0,3,7'h33), 32'hffff_ffff, 32'hffff_ffff, 5'd13, 32'h0, 32'h0, 1'b1, 1'b1, 32'hffff_fffe, 5'd13, 1'b0, 32'h0, 33});
    tbl.push_back('{mk(0,0,7'h33), 32'd3, 32'hffff_fffe, 5'd13, 32'h0, 32'h0, 1'b1, 1'b1, 32'hffff_fffa, 5'd13, 1'b0, 32'h0, 33});
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst.op", 32'(opcode_out), 32'd0);
    chk("rst.res", result_out, 32'd0);
    chk("rst.rd", 32'(Rd_out), 32'd0);
    chk("rst.sd", store_data_out, 32'd0);
    chk("rst.busy", 32'(busy_out), 32'd0);
    chk("rst.jmp", 32'(jump_flag_out), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) exec(tbl[i], $sformatf("vec%0d", i));

    // Stall held across a taken JAL: flag suppressed, EX/MEM frozen on the prior ADD.
    exec(tbl[0], "stall.pre");
    stall_in = 1'b1;
    opcode_in = mk(0,0,7'h6f); pc_in = 32'h300; imm_in = 32'h10; Rd_in = 5'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall.jmp", 32'(jump_flag_out), 32'd0);
      chk("stall.busy", 32'(busy_out), 32'd1);
      @(posedge clk); #1;
      chk("stall.res", result_out, 32'd12);
      chk("stall.op", 32'(opcode_out), 32'(mk(0,0,7'h33)));
    end
    stall_in = 1'b0;
    @(negedge clk);
    chk("unstall.jmp", 32'(jump_flag_out), 32'd1);
    chk("unstall.tgt", jump_target_out, 32'h310);
    @(posedge clk); #1;
    chk("unstall.res", result_out, 32'h304);
    chk("unstall.rd", 32'(Rd_out), 32'd1);

    // Asynchronous reset two edges into a 10-bit shift.
    opcode_in = mk(0,1,7'h13); data1_in = 32'd1; imm_in = 32'd10; Rd_in = 5'd4;
    @(negedge clk);
    chk("rsh.busy_pre", 32'(busy_out), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rsh.busy", 32'(busy_out), 32'd0);
    chk("rsh.jmp", 32'(jump_flag_out), 32'd0);
    chk("rsh.op", 32'(opcode_out), 32'd0);
    chk("rsh.res", result_out, 32'd0);
    chk("rsh.rd", 32'(Rd_out), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exec(tbl[0], "rsh.add");

    for (int n = 0; n < 150; n++) begin
      r = tbl[0];
      r.op = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pick($urandom_range(0, 10)));
      r.d1 = $urandom;
      r.d2 = ($urandom_range(0, 3) == 0) ? r.d1 : $urandom;
      r.rd = 5'($urandom);
      r.pc = $urandom;
      r.imm = $urandom;
      r.md = 1'b0;
`ifdef EX_MULDIV_EN
      if (r.op[6:0] == 7'h33 && $urandom_range(0, 2) == 0) begin
        r.md = 1'b1;
        if ($urandom_range(0, 4) == 0) r.d2 = '0;
      end
`endif
      model(r);
      exec(r, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ex_unit.md
Name: ex_unit

Overview:
- Execute stage of the RV32I pipeline. Consumes the ID/EX pipeline register outputs and computes ALU, address and link results. Resolves branches and jumps, and drives the ID/EX flush.
- Contains the EX/MEM output register.
- Shifts run serially (1 bit/cycle) under an FSM that stalls upstream stages via busy_out.

Parameters:
- XLEN, 32, datapath width (fixed at 32; not intended to vary)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- stall_in  in  1  downstream (memory) stall; freezes this unit
- opcode_in  in  11  {funct7[5], funct3, opcode[6:0]}; 0 = bubble
- data1_in  in  32  rs1 value
- data2_in  in  32  rs2 value
- Rd_in  in  5  destination register
- pc_in  in  32  instruction PC
- imm_in  in  32  sign-extended immediate
- opcode_out  out  11  registered opcode to MEM; 0 = bubble
- result_out  out  32  registered ALU result / memory address / link value
- store_data_out  out  32  registered data2 for stores
- Rd_out  out  5  registered destination
- busy_out  out  1  combinational; stalls IF/ID/ID_EX
- jump_flag_out  out  1  combinational; taken branch/jump, flushes ID_EX
- jump_target_out  out  32  combinational redirect PC

Behaviour:
- Reset (async): FSM=IDLE; all registered outputs 0; shift counter and accumulator 0. busy_out and jump_flag_out evaluate to 0. Reset mid-shift abandons the shift immediately.
- FSM states: IDLE, SHIFT, DONE (plus MULDIV with the optional feature).
- Decode in IDLE, using opcode_in[6:0]:
  - LUI: result = imm.
  - AUIPC: result = pc+imm.
  - OP-IMM: data1 op imm.
  - OP: data1 op data2; SUB when bit10=1.
  - LOAD/STORE: result = data1+imm.
  - JAL/JALR: result = pc+4.
  - BRANCH: result = 0; Rd_out = 0.
- SLT/SLTU give a 0/1 result. All arithmetic is mod 2^32.
- Unrecognised opcode (including 0): registered as a bubble (opcode/Rd/result = 0).
- Single-cycle ops: outputs are registered at the next edge; busy_out = 0.
- Shifts (SLL/SRL/SRA, imm or reg): shamt = operand[4:0]; bit10 selects SRA.
  - shamt = 0: single-cycle; result = data1.
  - shamt > 0, IDLE cycle: busy_out = 1; acc ← data1; cnt ← shamt; →SHIFT.
  - SHIFT: busy_out = 1; shift acc by 1 each cycle; cnt−1; when cnt = 1 →DONE.
  - DONE: busy_out = 0; outputs ← acc with opcode/Rd; →IDLE. Inputs are ignored in DONE.
  - Total busy cycles = shamt+1.
- While busy_out = 1 from internal state, output registers load a bubble each edge so MEM never duplicates an instruction.
- Jumps/branches (IDLE only):
  - JAL target = pc+imm.
  - JALR target = (data1+imm) & ~1.
  - Branch target = pc+imm when the condition (BEQ/BNE/BLT/BGE/BLTU/BGEU) holds.
  - jump_flag_out = 1 for the same cycle. Not taken: flag 0, target 0.
  - No misalignment check.
- stall_in = 1:
  - FSM, counter and output registers hold.
  - busy_out = 1.
  - jump_flag_out forced to 0; the jump re-evaluates once the stall releases.
- Simultaneous stall_in and rst: rst wins.

Optional Feature:
- Macro EX_MULDIV_EN. When defined:
  - Adds input port muldiv_in (1 bit, funct7[0]).
  - OP with muldiv_in = 1 executes the funct3-selected op: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
  - Iterative, 32 cycles in state MULDIV; busy cycles = 33, then DONE as for shifts.
  - Divide by 0: quotient 0xFFFFFFFF, remainder = dividend.
  - 0x80000000 / −1: quotient 0x80000000, remainder 0.
- When not defined: port absent; OP decodes on bit10 only; MULDIV state absent.

Test Plan:
- ADD, data1=5, data2=7, Rd=3 -> next edge result_out=12, Rd_out=3, busy_out=0 throughout.
- SLLI data1=1, imm=3 -> busy_out high 4 cycles with bubble outputs; then result_out=8 and busy_out=0. Repeat with SRAI data1=0x80000000, shamt=4 -> 0xF8000000.
- BEQ data1=data2=9, pc=0x100, imm=0x20 -> jump_flag_out=1, target=0x120 in the same cycle. With data2=8 -> flag=0.
- JALR data1=0x1003, imm=4, pc=0x40 -> target=0x1006, result_out=0x44.
- rst asserted 2 cycles into a SLLI by 10 -> busy_out=0 and outputs 0 immediately (asynchronous). Next ADD executes normally.
- stall_in held 3 cycles during a taken JAL -> jump_flag_out=0 and outputs frozen while stalled; flag=1 on the first unstalled cycle. With EX_MULDIV_EN, DIV 7/0 -> 0xFFFFFFFF after 33 busy cycles.
